// File: rtl/i2c_target_regs_if.sv
// Parallel register port between the I2C target and a byte-wide register file.
interface i2c_target_regs_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       reg_re;
  logic       active;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re, active,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re, active,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 256-byte register space with auto-incrementing pointer.
// Bus events act 3 clocks after the pins move (sync + edge detect); SCL is never stretched.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i2c_sclk,
  inout  wire               i2c_sdat,
  i2c_target_regs_if.master regs
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] PTR      = 4'd3;
  localparam logic [3:0] WR_BYTE  = 4'd4;
  localparam logic [3:0] WR_ACK   = 4'd5;
  localparam logic [3:0] RD_BYTE  = 4'd6;
  localparam logic [3:0] RD_ACK   = 4'd7;
  localparam logic [3:0] IGNORE   = 4'd8;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sda_oe;
  logic       rw;
  logic       rd_load;
  logic       incr_pend;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       byte_done, addr_match, rd_load_now;
  logic [7:0] rx_byte;

  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

  // Sync flops reset high (idle bus) so reset release cannot fake a START.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= i2c_sclk;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= i2c_sdat;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise   = scl_s2 & ~scl_h;
  assign scl_fall   = ~scl_s2 & scl_h;
  assign start_det  = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det   = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign rx_byte    = {shreg[6:0], sda_s2};
  assign byte_done  = scl_rise && (bit_cnt == 3'd7);
  assign addr_match = (rx_byte[7:1] == DEV_ADDR) && (rx_byte[7:1] != 7'd0);

  // Read data is fetched on the SCL fall that ends either the address ACK or a controller ACK.
  assign rd_load_now = scl_fall &&
                       (((state == ADDR_ACK) && sda_oe && rw) ||
                        ((state == RD_BYTE) && rd_load));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      shreg          <= 8'd0;
      sda_oe         <= 1'b0;
      rw             <= 1'b0;
      rd_load        <= 1'b0;
      incr_pend      <= 1'b0;
      regs.reg_addr  <= 8'd0;
      regs.reg_wdata <= 8'd0;
      regs.reg_we    <= 1'b0;
      regs.reg_re    <= 1'b0;
      regs.active    <= 1'b0;
    end else begin
      regs.reg_we <= 1'b0;
      regs.reg_re <= 1'b0;
      incr_pend   <= 1'b0;
      // Pointer moves the clock after a strobe so the strobe sees the accessed address.
      if (incr_pend) begin
        regs.reg_addr <= regs.reg_addr + 8'd1;
      end

      if (stop_det) begin
        state       <= IDLE;
        sda_oe      <= 1'b0;
        regs.active <= 1'b0;
        bit_cnt     <= 3'd0;
        rd_load     <= 1'b0;
      end else if (start_det) begin
        state       <= ADDR;
        sda_oe      <= 1'b0;
        regs.active <= 1'b0;
        bit_cnt     <= 3'd0;
        rd_load     <= 1'b0;
      end else if (rd_load_now) begin
        shreg       <= regs.reg_rdata;
        sda_oe      <= ~regs.reg_rdata[7];
        regs.reg_re <= 1'b1;
        incr_pend   <= 1'b1;
        bit_cnt     <= 3'd0;
        rd_load     <= 1'b0;
        state       <= RD_BYTE;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (addr_match) begin
                  state <= ADDR_ACK;
                  rw    <= rx_byte[0];
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end

          // First fall starts driving ACK, second fall ends it (read path handled above).
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe      <= 1'b1;
                regs.active <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= PTR;
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                regs.reg_addr <= rx_byte;
                state         <= WR_ACK;
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                regs.reg_wdata <= rx_byte;
                regs.reg_we    <= 1'b1;
                incr_pend      <= 1'b1;
                state          <= WR_ACK;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= WR_BYTE;
              end
            end
          end

          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                state   <= RD_BYTE;
                rd_load <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end

          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

endmodule
